// File: rtl/lisp_pkg.sv
// Shared constants and types for the memory-side blocks.
// Word memory geometry and the arbiter's transaction states.
package lisp_pkg;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// Round-robin first-set-bit finder: searches req upward from ptr, wrapping,
// and returns the winner as one-hot and as an index.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);
    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                idx      = IDX_W'(j);
                grant[j] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter in front of the single-port word memory, with a
// watchdog that completes a transaction with ERR_OUT if DATA_READY never comes.
module mem_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = lisp_pkg::ADDR_W,
    parameter int DATA_W  = lisp_pkg::DATA_W,
    parameter int TIMEOUT = 15
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NUM_REQ-1:0]        REQ_IN,
    input  logic [NUM_REQ*ADDR_W-1:0] ADDR_IN,
    output logic [NUM_REQ-1:0]        ACK_OUT,
    output logic [DATA_W-1:0]         DATA_OUT,
    output logic                      ERR_OUT,
    output logic [NUM_REQ-1:0]        GRANT_OUT,
    output logic                      MEM_REQ,
    output logic [ADDR_W-1:0]         MEM_ADDR,
    input  logic                      MEM_DATA_READY,
    input  logic [DATA_W-1:0]         MEM_DATA
);
    import lisp_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t         state, state_nxt;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   winner;
    logic [7:0]         cnt;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               timeout_hit;

    rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req   (REQ_IN),
        .ptr   (ptr),
        .grant (pick_gnt),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Last permitted WAIT cycle; the counter starts at 0 on the first one.
    assign timeout_hit = (cnt == 8'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_any) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (MEM_DATA_READY || timeout_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign MEM_REQ = (state == ISSUE);
    assign ACK_OUT = (state == DONE) ? GRANT_OUT : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            ptr       <= '0;
            winner    <= '0;
            cnt       <= '0;
            GRANT_OUT <= '0;
            MEM_ADDR  <= '0;
            DATA_OUT  <= '0;
            ERR_OUT   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        GRANT_OUT <= pick_gnt;
                        winner    <= pick_idx;
                        MEM_ADDR  <= ADDR_IN[pick_idx*ADDR_W +: ADDR_W];
                    end
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    // Data arriving on the final cycle still beats the watchdog.
                    if (MEM_DATA_READY) begin
                        DATA_OUT <= MEM_DATA;
                        ERR_OUT  <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                        if (timeout_hit) begin
                            DATA_OUT <= '0;
                            ERR_OUT  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    ptr       <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                    GRANT_OUT <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-timeline model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_mem_arbiter;
    localparam int NR   = 2;
    localparam int AW   = 12;
    localparam int DW   = 16;
    localparam int TOUT = 15;

    logic                 CLK, RST;
    logic [NR-1:0]        REQ_IN;
    logic [NR*AW-1:0]     ADDR_IN;
    logic [NR-1:0]        ACK_OUT, GRANT_OUT;
    logic [DW-1:0]        DATA_OUT, MEM_DATA;
    logic                 ERR_OUT, MEM_REQ, MEM_DATA_READY;
    logic [AW-1:0]        MEM_ADDR;

    mem_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TOUT)) dut (
        .CLK(CLK), .RST(RST), .REQ_IN(REQ_IN), .ADDR_IN(ADDR_IN),
        .ACK_OUT(ACK_OUT), .DATA_OUT(DATA_OUT), .ERR_OUT(ERR_OUT),
        .GRANT_OUT(GRANT_OUT), .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR),
        .MEM_DATA_READY(MEM_DATA_READY), .MEM_DATA(MEM_DATA)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] memw(input logic [AW-1:0] a);
        if (a == 12'h000) return 16'h0000;
        if (a == 12'h001) return 16'hBEEF;
        return {4'hA, a};
    endfunction

    // Stimulus state, written by main at negedge, applied by the driver after posedge.
    int                rq_cnt [NR];
    logic [NR-1:0]     ack_flag;
    logic [NR-1:0][AW-1:0] addr_v;
    logic              rst_req;
    int                mem_lat;    // 0 = memory never answers

    initial begin
        RST = 1'b1; REQ_IN = '0; ADDR_IN = '0;
        MEM_DATA_READY = 1'b0; MEM_DATA = '0;
        forever begin
            @(posedge CLK);
            #1;
            RST = rst_req;
            for (int i = 0; i < NR; i++) begin
                if (ack_flag[i]) begin
                    if (rq_cnt[i] > 0) rq_cnt[i]--;
                    ack_flag[i] = 1'b0;
                end
                REQ_IN[i] = (rq_cnt[i] > 0);
            end
            ADDR_IN = addr_v;
        end
    end

    // Memory: answers mem_lat cycles after it sees MEM_REQ.
    int         rd_cd = 0;
    logic [AW-1:0] rd_addr = '0;
    initial forever begin
        @(negedge CLK);
        if (MEM_REQ === 1'b1 && mem_lat > 0) begin
            rd_cd   = mem_lat;
            rd_addr = MEM_ADDR;
        end
    end
    initial forever begin
        @(posedge CLK);
        #1;
        MEM_DATA_READY = 1'b0;
        if (rd_cd > 0) begin
            rd_cd--;
            if (rd_cd == 0) begin
                MEM_DATA_READY = 1'b1;
                MEM_DATA       = memw(rd_addr);
            end
        end
    end

    typedef struct { int c; logic [NR-1:0] ack; logic [DW-1:0] d; logic e; } ack_t;
    ack_t alog[$];
    int   mq_c[$];
    logic [AW-1:0] mq_a[$];

    // Model: each transaction is a timeline (start s, MEM_REQ at s+1, ACK at end).
    int            m_busy = 0, m_start = 0, m_end = 0, m_win = 0, m_ptr = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0, m_rdata = '0;
    logic          m_err = 1'b0, m_rerr = 1'b0;

    initial forever begin
        logic [NR-1:0] e_grant, e_ack;
        logic          e_mreq;
        int            j;
        @(negedge CLK);
        e_grant = m_busy ? NR'(1 << m_win) : '0;
        e_ack   = (m_busy && cyc == m_end) ? NR'(1 << m_win) : '0;
        e_mreq  = m_busy && (cyc == m_start + 1);
        if (m_busy && cyc == m_end) begin
            m_data = m_rdata;
            m_err  = m_rerr;
        end
        check("grant", GRANT_OUT, e_grant);
        check("ack", ACK_OUT, e_ack);
        check("mem_req", MEM_REQ, e_mreq);
        check("mem_addr", MEM_ADDR, m_addr);
        check("data", DATA_OUT, m_data);
        check("err", ERR_OUT, m_err);

        if (ACK_OUT !== '0) begin
            alog.push_back('{cyc, ACK_OUT, DATA_OUT, ERR_OUT});
            ack_flag = ack_flag | ACK_OUT;
        end
        if (MEM_REQ === 1'b1) begin
            mq_c.push_back(cyc);
            mq_a.push_back(MEM_ADDR);
        end

        if (RST) begin
            m_busy = 0; m_ptr = 0; m_addr = '0; m_data = '0; m_err = 1'b0;
        end else if (m_busy && cyc == m_end) begin
            m_busy = 0;
            m_ptr  = (m_win + 1) % NR;
        end else if (!m_busy && REQ_IN != '0) begin
            for (int k = NR - 1; k >= 0; k--) begin
                j = (m_ptr + k) % NR;
                if (REQ_IN[j]) m_win = j;
            end
            m_busy  = 1;
            m_start = cyc;
            m_addr  = ADDR_IN[m_win*AW +: AW];
            if (mem_lat != 0 && mem_lat <= TOUT) begin
                m_end = cyc + 2 + mem_lat; m_rdata = memw(m_addr); m_rerr = 1'b0;
            end else begin
                m_end = cyc + 2 + TOUT;    m_rdata = '0;           m_rerr = 1'b1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic chk_ack(input string nm, input int k, input int ecyc,
                           input logic [NR-1:0] eack, input logic [DW-1:0] ed, input logic ee);
        check({nm, "_present"}, 32'(alog.size() > k), 1);
        if (alog.size() > k) begin
            check({nm, "_cycle"}, alog[k].c, ecyc);
            check({nm, "_who"},   alog[k].ack, eack);
            check({nm, "_data"},  alog[k].d, ed);
            check({nm, "_err"},   alog[k].e, ee);
        end
    endtask

    int c0;
    initial begin
        rst_req = 1'b1; mem_lat = 1; ack_flag = '0; addr_v = '0;
        for (int i = 0; i < NR; i++) rq_cnt[i] = 0;
        tick(3);
        rst_req = 1'b0;
        tick(2);
        check("rst_grant", GRANT_OUT, 0);
        check("rst_ack", ACK_OUT, 0);
        check("rst_memreq", MEM_REQ, 0);
        check("rst_data", DATA_OUT, 0);

        // Simultaneous after reset: requester 0 first
        alog.delete(); c0 = cyc;
        addr_v[0] = 12'h000; addr_v[1] = 12'h001; rq_cnt[0] = 1; rq_cnt[1] = 1;
        tick(10);
        chk_ack("sim0", 0, c0 + 4, 2'b01, 16'h0000, 1'b0);
        chk_ack("sim1", 1, c0 + 8, 2'b10, 16'hBEEF, 1'b0);

        // Fairness: both keep requesting for 8 transactions
        alog.delete(); c0 = cyc;
        addr_v[0] = 12'h002; addr_v[1] = 12'h003; rq_cnt[0] = 4; rq_cnt[1] = 4;
        tick(34);
        check("fair_count", alog.size(), 8);
        for (int k = 0; k < 8; k++)
            chk_ack("fair", k, c0 + 4 + 4*k, (k % 2 == 0) ? 2'b01 : 2'b10,
                    (k % 2 == 0) ? 16'hA002 : 16'hA003, 1'b0);

        // Single requester
        alog.delete(); mq_c.delete(); mq_a.delete(); c0 = cyc;
        addr_v[0] = 12'h001; rq_cnt[0] = 1;
        tick(6);
        check("single_memreq_present", 32'(mq_c.size() > 0), 1);
        if (mq_c.size() > 0) begin
            check("single_memreq_cycle", mq_c[0], c0 + 2);
            check("single_memreq_addr", mq_a[0], 12'h001);
        end
        chk_ack("single", 0, c0 + 4, 2'b01, 16'hBEEF, 1'b0);

        // Timeout: memory never answers
        alog.delete(); c0 = cyc; mem_lat = 0;
        addr_v[1] = 12'h005; rq_cnt[1] = 1;
        tick(20);
        chk_ack("tmo", 0, c0 + 18, 2'b10, 16'h0000, 1'b1);

        // Next normal transaction clears ERR_OUT
        alog.delete(); c0 = cyc; mem_lat = 1;
        addr_v[0] = 12'h006; rq_cnt[0] = 1;
        tick(6);
        chk_ack("after_tmo", 0, c0 + 4, 2'b01, 16'hA006, 1'b0);

        // Ready on the final WAIT cycle: data wins
        alog.delete(); c0 = cyc; mem_lat = TOUT;
        addr_v[1] = 12'h001; rq_cnt[1] = 1;
        tick(20);
        chk_ack("coinc", 0, c0 + 18, 2'b10, 16'hBEEF, 1'b0);

        // Ready one cycle too late: timeout, late strobe ignored
        alog.delete(); c0 = cyc; mem_lat = TOUT + 1;
        addr_v[0] = 12'h007; rq_cnt[0] = 1;
        tick(22);
        chk_ack("late", 0, c0 + 18, 2'b01, 16'h0000, 1'b1);
        check("late_hold", DATA_OUT, 16'h0000);

        // Load DATA_OUT, leaving pointer at 1
        alog.delete(); c0 = cyc; mem_lat = 1;
        addr_v[0] = 12'h001; rq_cnt[0] = 1;
        tick(6);
        chk_ack("pre_rst", 0, c0 + 4, 2'b01, 16'hBEEF, 1'b0);

        // Reset during WAIT, then a stray DATA_READY
        alog.delete(); c0 = cyc; mem_lat = 5;
        addr_v[0] = 12'h002; rq_cnt[0] = 1;
        tick(3);
        rst_req = 1'b1; rq_cnt[0] = 0;
        tick(1);
        rst_req = 1'b0;
        tick(1);
        check("mid_rst_grant", GRANT_OUT, 0);
        check("mid_rst_addr", MEM_ADDR, 0);
        check("mid_rst_data", DATA_OUT, 0);
        check("mid_rst_ack", ACK_OUT, 0);
        tick(5);
        check("mid_rst_no_ack", alog.size(), 0);
        check("stray_ready_ignored", DATA_OUT, 0);

        // Pointer reset to 0: requester 0 wins first
        alog.delete(); c0 = cyc; mem_lat = 1;
        addr_v[0] = 12'h003; addr_v[1] = 12'h004; rq_cnt[0] = 1; rq_cnt[1] = 1;
        tick(10);
        chk_ack("ptr0_a", 0, c0 + 4, 2'b01, 16'hA003, 1'b0);
        chk_ack("ptr0_b", 1, c0 + 8, 2'b10, 16'hA004, 1'b0);

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port word memory (12-bit address, 16-bit data, one-cycle REQ pulse, DATA_READY one cycle later) between NUM_REQ requesters, e.g. the evaluator, the GC and the loader.
- Round-robin arbitration with a level request / single-cycle acknowledge per requester.
- Sits directly in front of the memory and owns its REQ and ADDR_IN pins.
- A watchdog ends any transaction whose DATA_READY never arrives and flags an error.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- ADDR_W, 12, address width.
- DATA_W, 16, data width.
- TIMEOUT, 15, maximum wait cycles for MEM_DATA_READY after MEM_REQ before aborting; range 1..255.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- REQ_IN  in  NUM_REQ  per-requester level request; held until its ACK_OUT bit is sampled high
- ADDR_IN  in  NUM_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
- ACK_OUT  out  NUM_REQ  one-hot, one-cycle pulse: DATA_OUT/ERR_OUT valid for that requester
- DATA_OUT  out  DATA_W  read data, registered
- ERR_OUT  out  1  high with ACK_OUT when the transaction timed out
- GRANT_OUT  out  NUM_REQ  one-hot current owner; 0 in IDLE
- MEM_REQ  out  1  one-cycle request pulse to memory
- MEM_ADDR  out  ADDR_W  address to memory, held stable from ISSUE through WAIT
- MEM_DATA_READY  in  1  memory read-complete strobe
- MEM_DATA  in  DATA_W  memory read data

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer 0, timeout counter 0.
- A reset asserted mid-transaction abandons it; no ACK is issued. Any late MEM_DATA_READY after reset is ignored.
- State machine: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE:
  - If any REQ_IN bit is high, pick the first set bit searching from pointer upward, wrapping at NUM_REQ-1 to 0.
  - Register GRANT_OUT and MEM_ADDR from the winner's ADDR_IN slice; go to ISSUE.
  - If no REQ_IN bit is high, stay in IDLE.
- ISSUE:
  - MEM_REQ=1 for exactly this cycle; clear the counter; go to WAIT.
- WAIT:
  - If MEM_DATA_READY=1, latch DATA_OUT<=MEM_DATA, ERR_OUT<=0, go to DONE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT, set DATA_OUT<=0, ERR_OUT<=1, go to DONE.
  - If MEM_DATA_READY and the timeout coincide, data wins and ERR_OUT=0.
- DONE:
  - ACK_OUT = GRANT_OUT for one cycle; DATA_OUT and ERR_OUT stay valid this cycle.
  - Pointer <= (winner+1) mod NUM_REQ; GRANT_OUT <= 0 on exit; go to IDLE.
- Latency with the standard memory: REQ_IN sampled at cycle 0 edge -> MEM_REQ in cycle 1 -> MEM_DATA_READY in cycle 2 -> ACK_OUT in cycle 3. Back-to-back grants start every 4 cycles.
- Requester contract:
  - Hold REQ_IN and the address stable until ACK_OUT is sampled.
  - Deassert on that edge. IDLE in cycle 4 therefore never re-grants a finished request.
  - The address is captured in IDLE, so changes after the grant are ignored.
  - Dropping REQ_IN before ACK does not cancel an issued transaction; its ACK is still generated.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 transactions.
- MEM_DATA_READY outside WAIT is ignored.
- DATA_OUT holds its last value between ACKs.
- ERR_OUT clears on the next transaction's completion.

Decomposition:
- Shared package (lisp_pkg, extend if present): ADDR_W/DATA_W constants and arbiter state enum arb_state_t {IDLE, ISSUE, WAIT, DONE}.
- One natural sub-module: rr_pick, a combinational round-robin first-set-bit finder over (REQ_IN, pointer) returning a one-hot grant and winner index.
- All sequential logic stays in mem_arbiter.

Test Plan:
- Single requester: REQ_IN=2'b01, ADDR0=12'h001, memory word 1 = 16'hBEEF -> MEM_REQ in cycle 1 with MEM_ADDR=12'h001; ACK_OUT=2'b01 in cycle 3 with DATA_OUT=16'hBEEF, ERR_OUT=0.
- Simultaneous requests after reset: REQ_IN=2'b11, ADDR0=12'h000, ADDR1=12'h001 -> requester 0 ACKed first with 16'h0000, then requester 1 ACKed 4 cycles later with 16'hBEEF.
- Fairness: both requesters reassert after every ACK for 8 transactions -> ACK order alternates 0,1,0,1…; no requester is served twice in a row while the other waits.
- Timeout: memory model never raises DATA_READY, TIMEOUT=15 -> ACK_OUT pulses with ERR_OUT=1 and DATA_OUT=0, 15 cycles after the WAIT counter starts. The next normal transaction returns ERR_OUT=0.
- Reset mid-operation: assert RST during WAIT -> the next cycle shows all outputs 0, no ACK, pointer 0. A stray MEM_DATA_READY afterwards is ignored.
- Coincident ready and timeout: DATA_READY arrives on the TIMEOUT cycle -> ERR_OUT=0 and DATA_OUT=MEM_DATA.
